rand_coord_gen: RTL and testbench
=================================

Name: rand_coord_gen

Overview:
- Consumes the 8-bit LFSR byte stream from the Random block, one byte per clock.
- Assembles bytes into an on-screen pixel coordinate, using rejection sampling to reject out-of-range values.
- Presents the coordinate to the downstream draw stage (starfield / sprite placer) over a valid/ready handshake.
- Sits directly downstream of Random in the VGA graphics pipeline.

Parameters:
- H_RES, 640, visible width; accepted X is 0..H_RES-1.
- V_RES, 480, visible height; accepted Y is 0..V_RES-1.
- X_W, 10, X coordinate width in bits.
- Y_W, 9, Y coordinate width in bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- random  in  8  byte from the Random LFSR; a new value arrives every cycle.
- gen_en  in  1  while high, a byte is consumed each cycle in a GET state.
- coord_ready  in  1  downstream accepts the coordinate.
- coord_valid  out  1  x/y hold a valid coordinate.
- x  out  X_W  X coordinate.
- y  out  Y_W  Y coordinate.
- reject_cnt  out  8  saturating count of rejected samples.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=GET_XL; coord_valid=0; x=0; y=0; reject_cnt=0.
  - Reset overrides everything, including mid-assembly and HOLD. Any partial coordinate is discarded.
- FSM states: GET_XL, GET_XH, GET_YL, GET_YH, HOLD.
- GET states:
  - Advance only on edges where gen_en=1; with gen_en=0 the state and partial registers hold.
  - GET_XL: latch xl=random; go to GET_XH.
  - GET_XH: cand = {random[1:0], xl}.
    - If cand < H_RES: x<=cand; go to GET_YL.
    - Else: go to GET_XL and increment reject_cnt (saturates at 255).
  - GET_YL: latch yl=random; go to GET_YH.
  - GET_YH: cand = {random[0], yl}.
    - If cand < V_RES: y<=cand; go to HOLD; coord_valid=1 from the next cycle.
    - Else: go to GET_YL (X is kept) and increment reject_cnt.
  - random bits above the field width are ignored.
- HOLD:
  - coord_valid=1; x and y are stable; random and gen_en are ignored.
  - A transfer occurs on an edge with coord_valid=1 and coord_ready=1. Then coord_valid<=0 and state<=GET_XL.
  - coord_ready with coord_valid=0 has no effect.
  - x and y keep their last values after a transfer; they are only meaningful while coord_valid=1.
- Latency and throughput:
  - Minimum 4 enabled cycles from GET_XL to coord_valid=1.
  - Maximum throughput is one coordinate per 5 cycles; there is no overlap of assembly with HOLD.
- Comparisons are unsigned, done at full candidate width (10 bits for X, 9 bits for Y).

Optional Feature:
- Macro: RAND_COORD_COLOR_EN.
- Defined:
  - Adds port color out 8.
  - Adds state GET_C between GET_YH-accept and HOLD; it latches color=random when gen_en=1.
  - Minimum latency becomes 5 cycles; color reset value is 0; color is stable in HOLD.
- Undefined: no color port and no GET_C state; behaviour is exactly as above.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES/V_RES defaults and X_W/Y_W.
  - The coord_state_t enum (GET_XL..HOLD, GET_C).
- No sub-module: the range checks are two inline compares, and the FSM is small enough to stay flat.

Test Plan:
- Reset, then check outputs:
  - Hold rst=1 for 2 edges -> coord_valid=0, x=0, y=0, reject_cnt=0.
  - Release rst with gen_en=1, coord_ready=0, random=0x00 for 4 edges -> coord_valid=1, x=0, y=0.
- Nominal:
  - Drive random 0x10,0x01,0x20,0x01 on consecutive edges with gen_en=1 -> after the 4th edge, coord_valid=1, x=272, y=288.
- Rejection:
  - X sequence 0x80,0x02 (cand 640) is rejected and reject_cnt=1. Then 0x7F,0x02 is accepted with x=639.
  - Y sequence 0xE0,0x01 (cand 480) is rejected and reject_cnt=2. Then 0xDF,0x01 is accepted with y=479.
  - Valid asserts after 8 edges in total.
- Backpressure:
  - In HOLD, keep coord_ready=0 for 10 cycles while random toggles -> x and y stay unchanged and coord_valid stays 1.
  - Raise coord_ready for 1 edge -> coord_valid=0 next cycle; the next valid is no earlier than 4 edges later.
- Pause and reset:
  - Drop gen_en after GET_XL for 3 cycles -> no progress; the final coordinate uses the byte present when gen_en returns.
  - Assert rst while in GET_YH -> next cycle state=GET_XL, coord_valid=0, reject_cnt=0.

Source files
------------

// File: rtl/rand_coord_gen_pkg.sv
// ----------------------------------------------------------------------------
// Module : vga_pkg
// Shared VGA pipeline constants and the coordinate generator state encoding.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;
  localparam int unsigned X_W           = 10;
  localparam int unsigned Y_W           = 9;

  // GET_C is only entered when the colour byte is enabled.
  typedef enum logic [2:0] {
    GET_XL = 3'd0,
    GET_XH = 3'd1,
    GET_YL = 3'd2,
    GET_YH = 3'd3,
    HOLD   = 3'd4,
    GET_C  = 3'd5
  } coord_state_t;

endpackage

`default_nettype wire

// File: rtl/rand_coord_gen_if.sv
// ----------------------------------------------------------------------------
// Module : rand_coord_gen_if
// Random byte input plus coordinate valid/ready bundle; colour when RAND_COORD_COLOR_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rand_coord_gen_if;
  import vga_pkg::*;

  logic [7:0]     random;
  logic           gen_en;
  logic           coord_ready;
  logic           coord_valid;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [7:0]     reject_cnt;
`ifdef RAND_COORD_COLOR_EN
  logic [7:0]     color;

  modport master (
    input  random, gen_en, coord_ready,
    output coord_valid, x, y, reject_cnt, color
  );
  modport slave (
    output random, gen_en, coord_ready,
    input  coord_valid, x, y, reject_cnt, color
  );
`else
  modport master (
    input  random, gen_en, coord_ready,
    output coord_valid, x, y, reject_cnt
  );
  modport slave (
    output random, gen_en, coord_ready,
    input  coord_valid, x, y, reject_cnt
  );
`endif

endinterface

`default_nettype wire

// File: rtl/rand_coord_gen.sv
// ----------------------------------------------------------------------------
// Module : rand_coord_gen
// Builds an in-range pixel coordinate from LFSR bytes by rejection sampling.
// Optional colour byte stage: define RAND_COORD_COLOR_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rand_coord_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEFAULT,
  parameter int unsigned V_RES = V_RES_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rand_coord_gen_if.master bus
);

  // Limits widened by one bit so a resolution equal to 2**W still compares correctly.
  localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(V_RES);

  coord_state_t   state_q;
  logic [7:0]     xl_q;
  logic [7:0]     yl_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           valid_q;
  logic [7:0]     rej_cnt_q;
  logic [7:0]     rej_cnt_d;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           x_ok;
  logic           y_ok;
`ifdef RAND_COORD_COLOR_EN
  logic [7:0]     color_q;
`endif

  assign cand_x    = {bus.random[1:0], xl_q};
  assign cand_y    = {bus.random[0], yl_q};
  assign x_ok      = ({1'b0, cand_x} < X_LIMIT);
  assign y_ok      = ({1'b0, cand_y} < Y_LIMIT);
  assign rej_cnt_d = (rej_cnt_q == 8'hFF) ? rej_cnt_q : rej_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GET_XL;
      xl_q      <= '0;
      yl_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      rej_cnt_q <= '0;
`ifdef RAND_COORD_COLOR_EN
      color_q   <= '0;
`endif
    end else begin
      case (state_q)
        GET_XL: begin
          if (bus.gen_en) begin
            xl_q    <= bus.random;
            state_q <= GET_XH;
          end
        end
        GET_XH: begin
          if (bus.gen_en) begin
            if (x_ok) begin
              x_q     <= cand_x;
              state_q <= GET_YL;
            end else begin
              rej_cnt_q <= rej_cnt_d;
              state_q   <= GET_XL;
            end
          end
        end
        GET_YL: begin
          if (bus.gen_en) begin
            yl_q    <= bus.random;
            state_q <= GET_YH;
          end
        end
        GET_YH: begin
          if (bus.gen_en) begin
            if (y_ok) begin
              y_q <= cand_y;
`ifdef RAND_COORD_COLOR_EN
              state_q <= GET_C;
`else
              state_q <= HOLD;
              valid_q <= 1'b1;
`endif
            end else begin
              // A bad Y keeps the accepted X and only resamples Y.
              rej_cnt_q <= rej_cnt_d;
              state_q   <= GET_YL;
            end
          end
        end
`ifdef RAND_COORD_COLOR_EN
        GET_C: begin
          if (bus.gen_en) begin
            color_q <= bus.random;
            state_q <= HOLD;
            valid_q <= 1'b1;
          end
        end
`endif
        HOLD: begin
          if (bus.coord_ready) begin
            valid_q <= 1'b0;
            state_q <= GET_XL;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= GET_XL;
        end
      endcase
    end
  end

  assign bus.coord_valid = valid_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.reject_cnt  = rej_cnt_q;
`ifdef RAND_COORD_COLOR_EN
  assign bus.color       = color_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rand_coord_gen.sv
// ----------------------------------------------------------------------------
// Module : tb_rand_coord_gen
// Scoreboard bench for rand_coord_gen (default build, colour stage disabled).
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rand_coord_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  logic   clk;
  logic   rst;
  int     n_tests;
  int     n_fail;
  coord_t exp_q[$];
  coord_t e;

  rand_coord_gen_if bus();

  rand_coord_gen #(.H_RES(640), .V_RES(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [7:0] r, input logic en, input logic rdy);
    bus.random      = r;
    bus.gen_en      = en;
    bus.coord_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Encodes a coordinate as four bytes, filling unused high bits with noise.
  task automatic send_coord(input int unsigned cx, input int unsigned cy, input logic rdy);
    logic [X_W-1:0] xv;
    logic [Y_W-1:0] yv;
    logic [7:0]     b;
    xv = X_W'(cx);
    yv = Y_W'(cy);
    exp_q.push_back({xv, yv});
    step(xv[7:0], 1'b1, rdy);
    b = {6'($urandom), xv[9:8]};
    step(b, 1'b1, rdy);
    step(yv[7:0], 1'b1, rdy);
    b = {7'($urandom), yv[8]};
    step(b, 1'b1, rdy);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.coord_valid); end
    n_tests++; if (bus.x !== 10'd0) begin n_fail++; $display("FAIL rst_x: got %0d want 0", bus.x); end
    n_tests++; if (bus.y !== 9'd0) begin n_fail++; $display("FAIL rst_y: got %0d want 0", bus.y); end
    n_tests++; if (bus.reject_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_rej: got %0d want 0", bus.reject_cnt); end
    rst = 1'b0;
    exp_q.push_back({10'd0, 9'd0});
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early_valid: got %b want 0", bus.coord_valid); end
    step(8'h00, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", bus.coord_valid); end
    n_tests++; if (bus.x !== e.x || bus.y !== e.y) begin n_fail++; $display("FAIL zero_xy: got %0d,%0d want %0d,%0d", bus.x, bus.y, e.x, e.y); end
    step(8'h00, 1'b0, 1'b1);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL zero_xfer: got %b want 0", bus.coord_valid); end
  endtask

  task automatic test_nominal;
    exp_q.push_back({10'd272, 9'd288});
    step(8'h10, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL nom_early_valid: got %b want 0", bus.coord_valid); end
    step(8'h01, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid: got %b want 1", bus.coord_valid); end
    n_tests++; if (bus.x !== e.x || bus.y !== e.y) begin n_fail++; $display("FAIL nom_xy: got %0d,%0d want %0d,%0d", bus.x, bus.y, e.x, e.y); end
    n_tests++; if (bus.reject_cnt !== 8'd0) begin n_fail++; $display("FAIL nom_rej: got %0d want 0", bus.reject_cnt); end
    step(8'h00, 1'b0, 1'b1);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL nom_xfer: got %b want 0", bus.coord_valid); end
  endtask

  task automatic test_rejection;
    exp_q.push_back({10'd639, 9'd479});
    step(8'h80, 1'b1, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    n_tests++; if (bus.reject_cnt !== 8'd1) begin n_fail++; $display("FAIL rej_x640: got %0d want 1", bus.reject_cnt); end
    step(8'h7F, 1'b1, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(8'hE0, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    n_tests++; if (bus.reject_cnt !== 8'd2) begin n_fail++; $display("FAIL rej_y480: got %0d want 2", bus.reject_cnt); end
    step(8'hDF, 1'b1, 1'b0);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL rej_early_valid: got %b want 0", bus.coord_valid); end
    step(8'h01, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1) begin n_fail++; $display("FAIL rej_valid: got %b want 1", bus.coord_valid); end
    n_tests++; if (bus.x !== e.x || bus.y !== e.y) begin n_fail++; $display("FAIL rej_xy: got %0d,%0d want %0d,%0d", bus.x, bus.y, e.x, e.y); end
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    send_coord(5, 7, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", bus.coord_valid); end
    for (int i = 0; i < 10; i++) begin
      step(8'($urandom), 1'($urandom), 1'b0);
      n_tests++;
      if (bus.coord_valid !== 1'b1 || bus.x !== e.x || bus.y !== e.y) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b %0d,%0d want v=1 %0d,%0d", i, bus.coord_valid, bus.x, bus.y, e.x, e.y);
      end
    end
    step(8'h00, 1'b1, 1'b1);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL bp_xfer: got %b want 0", bus.coord_valid); end
    // coord_ready held high through assembly must not disturb anything.
    exp_q.push_back({10'd123, 9'd456});
    step(8'h7B, 1'b1, 1'b1);
    step(8'hFC, 1'b1, 1'b1);
    step(8'hC8, 1'b1, 1'b1);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid: got %b want 0", bus.coord_valid); end
    step(8'hFF, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1 || bus.x !== e.x || bus.y !== e.y) begin n_fail++; $display("FAIL bp_next: got v=%b %0d,%0d want v=1 %0d,%0d", bus.coord_valid, bus.x, bus.y, e.x, e.y); end
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_pause;
    exp_q.push_back({10'd308, 9'd5});
    step(8'h34, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'($urandom), 1'b0, 1'b0);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid: got %b want 0", bus.coord_valid); end
    step(8'h01, 1'b1, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1 || bus.x !== e.x || bus.y !== e.y) begin n_fail++; $display("FAIL pause_xy: got v=%b %0d,%0d want v=1 %0d,%0d", bus.coord_valid, bus.x, bus.y, e.x, e.y); end
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      step(8'h03, 1'b1, 1'b0);
    end
    n_tests++; if (bus.reject_cnt !== 8'd255) begin n_fail++; $display("FAIL rej_sat: got %0d want 255", bus.reject_cnt); end
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL sat_valid: got %b want 0", bus.coord_valid); end
  endtask

  task automatic test_reset_midway;
    step(8'h10, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    rst = 1'b1;
    step(8'h01, 1'b1, 1'b0);
    rst = 1'b0;
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.coord_valid); end
    n_tests++; if (bus.reject_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_rej: got %0d want 0", bus.reject_cnt); end
    n_tests++; if (bus.x !== 10'd0 || bus.y !== 9'd0) begin n_fail++; $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", bus.x, bus.y); end
    exp_q.push_back({10'd426, 9'd187});
    step(8'hAA, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'hBB, 1'b1, 1'b0);
    n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_valid: got %b want 0", bus.coord_valid); end
    step(8'h00, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (bus.coord_valid !== 1'b1 || bus.x !== e.x || bus.y !== e.y) begin n_fail++; $display("FAIL mid_xy: got v=%b %0d,%0d want v=1 %0d,%0d", bus.coord_valid, bus.x, bus.y, e.x, e.y); end
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      send_coord($urandom_range(0, 639), $urandom_range(0, 479), 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (bus.coord_valid !== 1'b1 || bus.x !== e.x || bus.y !== e.y) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b %0d,%0d want v=1 %0d,%0d", i, bus.coord_valid, bus.x, bus.y, e.x, e.y);
      end
      step(8'($urandom), 1'($urandom), 1'b1);
      n_tests++; if (bus.coord_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_xfer[%0d]: got %b want 0", i, bus.coord_valid); end
    end
    n_tests++; if (bus.reject_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_rej: got %0d want 0", bus.reject_cnt); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.random      = 8'h00;
    bus.gen_en      = 1'b0;
    bus.coord_ready = 1'b0;
    test_reset();
    test_nominal();
    test_rejection();
    test_backpressure();
    test_pause();
    test_saturation();
    test_reset_midway();
    test_back_to_back();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
